// File: rtl/dac_channel_scheduler_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// spgd_dac_pkg : shared FSM state type and channel-address width helper for
//                the DAC channel scheduler.
// Revision     : 1.0
// ============================================================================
package spgd_dac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

  function automatic int ch_width(input int num_ch);
    return (num_ch <= 1) ? 1 : $clog2(num_ch);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dac_channel_scheduler_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// dac_channel_scheduler_if : converter operand/result and DAC write port.
// Revision                 : 1.0
// ============================================================================
interface dac_channel_scheduler_if #(
  parameter int FP_WIDTH  = 64,
  parameter int DAC_WIDTH = 14,
  parameter int CH_W      = 3
);
  logic [FP_WIDTH-1:0]  conv_in;
  logic [DAC_WIDTH-1:0] conv_out;
  logic [DAC_WIDTH-1:0] dac_data;
  logic [CH_W-1:0]      dac_addr;
  logic                 dac_wr;
  logic                 dac_ack;

  modport master (
    output conv_in, dac_data, dac_addr, dac_wr,
    input  conv_out, dac_ack
  );

  modport slave (
    input  conv_in, dac_data, dac_addr, dac_wr,
    output conv_out, dac_ack
  );
endinterface
`default_nettype wire

// File: rtl/dac_channel_scheduler_shadow_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// dac_shadow_bank : last-written code and valid bit per channel, with compare.
// Revision        : 1.0
// ============================================================================
module dac_shadow_bank #(
  parameter int DAC_WIDTH = 14,
  parameter int NUM_CH    = 8,
  parameter int CH_W      = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CH_W-1:0]      rd_ch_i,
  input  logic [DAC_WIDTH-1:0] code_i,
  output logic                 match_o,
  input  logic                 wr_en_i,
  input  logic [CH_W-1:0]      wr_ch_i,
  input  logic [DAC_WIDTH-1:0] wr_code_i
);
  logic [DAC_WIDTH-1:0] shadow_q [NUM_CH];
  logic [NUM_CH-1:0]    valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_ch_i] <= 1'b1;
    end
  end

  // Code storage needs no reset: it is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      shadow_q[wr_ch_i] <= wr_code_i;
    end
  end

  assign match_o = valid_q[rd_ch_i] && (shadow_q[rd_ch_i] == code_i);
endmodule
`default_nettype wire

// File: rtl/dac_channel_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// dac_channel_scheduler : snapshots NUM_CH channel values, runs each through a
//   shared converter and writes the code to the DAC via wr/ack handshake.
//   Optional macro SKIP_UNCHANGED_EN suppresses writes of unchanged codes.
// Revision : 1.0
// ============================================================================
module dac_channel_scheduler
  import spgd_dac_pkg::*;
#(
  parameter int FP_WIDTH     = 64,
  parameter int DAC_WIDTH    = 14,
  parameter int NUM_CH       = 8,
  parameter int CONV_LATENCY = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [NUM_CH*FP_WIDTH-1:0] fp_vec,
  dac_channel_scheduler_if.master    bus,
  output logic                       busy,
  output logic                       done
);
  localparam int CH_W  = ch_width(NUM_CH);
  localparam int LAT_W = (CONV_LATENCY < 2) ? 1 : $clog2(CONV_LATENCY + 1);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  state_e                     state_q, state_d;
  logic [NUM_CH*FP_WIDTH-1:0] bank_q, bank_d;
  logic [CH_W-1:0]            ch_q, ch_d, ch_nxt;
  logic [LAT_W-1:0]           lat_q, lat_d;
  logic [FP_WIDTH-1:0]        conv_in_q, conv_in_d;
  logic [DAC_WIDTH-1:0]       data_q, data_d;
  logic [CH_W-1:0]            addr_q, addr_d;
  logic                       wr_q, wr_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       enter_write;
  logic                       xfer;
  logic                       skip;

  assign ch_nxt = ch_q + CH_W'(1);
  assign xfer   = wr_q & bus.dac_ack;

`ifdef SKIP_UNCHANGED_EN
  dac_shadow_bank #(
    .DAC_WIDTH (DAC_WIDTH),
    .NUM_CH    (NUM_CH),
    .CH_W      (CH_W)
  ) u_shadow (
    .clk       (clk),
    .rst       (rst),
    .rd_ch_i   (ch_q),
    .code_i    (bus.conv_out),
    .match_o   (skip),
    .wr_en_i   (xfer),
    .wr_ch_i   (addr_q),
    .wr_code_i (data_q)
  );
`else
  assign skip = 1'b0;
`endif

  // The operand is loaded on entry to ISSUE so the converter sees it for the
  // whole ISSUE cycle; this keeps a combinational converter at 2 cycles/ch.
  always_comb begin
    state_d     = state_q;
    bank_d      = bank_q;
    ch_d        = ch_q;
    lat_d       = lat_q;
    conv_in_d   = conv_in_q;
    data_d      = data_q;
    addr_d      = addr_q;
    wr_d        = wr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    enter_write = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          bank_d    = fp_vec;
          ch_d      = '0;
          conv_in_d = fp_vec[FP_WIDTH-1:0];
          busy_d    = 1'b1;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        lat_d = LAT_W'(CONV_LATENCY);
        if (CONV_LATENCY == 0) begin
          enter_write = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (lat_q == LAT_W'(1)) begin
          enter_write = 1'b1;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      ST_WRITE: begin
        // A suppressed write leaves wr low, so the channel retires at once.
        if (!wr_q || xfer) begin
          wr_d = 1'b0;
          if (ch_q == LAST_CH) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_FIN;
          end else begin
            ch_d      = ch_nxt;
            conv_in_d = bank_q[int'(ch_nxt)*FP_WIDTH +: FP_WIDTH];
            state_d   = ST_ISSUE;
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (enter_write) begin
      data_d  = bus.conv_out;
      addr_d  = ch_q;
      wr_d    = ~skip;
      state_d = ST_WRITE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bank_q    <= '0;
      ch_q      <= '0;
      lat_q     <= '0;
      conv_in_q <= '0;
      data_q    <= '0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bank_q    <= bank_d;
      ch_q      <= ch_d;
      lat_q     <= lat_d;
      conv_in_q <= conv_in_d;
      data_q    <= data_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.conv_in  = conv_in_q;
  assign bus.dac_data = data_q;
  assign bus.dac_addr = addr_q;
  assign bus.dac_wr   = wr_q;
  assign busy         = busy_q;
  assign done         = done_q;
endmodule
`default_nettype wire

// File: tb/tb_dac_channel_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_dac_channel_scheduler : randomized frames on a latency-1 and a latency-0
//   scheduler, checked against a frame-level write list and timing model.
// Revision : 1.0
// ============================================================================
module tb_dac_channel_scheduler;
  import spgd_dac_pkg::*;

  localparam int FP_W  = 64;
  localparam int DAC_W = 14;
  localparam int NCH   = 8;
  localparam int CHW   = ch_width(NCH);
`ifdef SKIP_UNCHANGED_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start0, start1;
  logic [NCH*FP_W-1:0]   fp_vec;
  logic                  busy0, busy1, done0, done1;

  always #5 clk = ~clk;

  dac_channel_scheduler_if #(.FP_WIDTH(FP_W), .DAC_WIDTH(DAC_W), .CH_W(CHW)) bus1 ();
  dac_channel_scheduler_if #(.FP_WIDTH(FP_W), .DAC_WIDTH(DAC_W), .CH_W(CHW)) bus0 ();

  dac_channel_scheduler #(
    .FP_WIDTH(FP_W), .DAC_WIDTH(DAC_W), .NUM_CH(NCH), .CONV_LATENCY(1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .fp_vec(fp_vec),
    .bus(bus1.master), .busy(busy1), .done(done1)
  );

  dac_channel_scheduler #(
    .FP_WIDTH(FP_W), .DAC_WIDTH(DAC_W), .NUM_CH(NCH), .CONV_LATENCY(0)
  ) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .fp_vec(fp_vec),
    .bus(bus0.master), .busy(busy0), .done(done0)
  );

  // Stub converters: low code bits of the operand, after the configured delay.
  always @(posedge clk) bus1.conv_out <= bus1.conv_in[DAC_W-1:0];
  assign bus0.conv_out = bus0.conv_in[DAC_W-1:0];
  assign bus0.dac_ack  = 1'b1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: expected write list per frame, plus last-written codes.
  int                qa0[$], qd0[$], qa1[$], qd1[$];
  logic [DAC_W-1:0]  sh_code [2][NCH];
  bit                sh_vld  [2][NCH];

  task automatic plan(input int which, input logic [NCH*FP_W-1:0] vec);
    for (int k = 0; k < NCH; k++) begin
      logic [DAC_W-1:0] code;
      code = vec[k*FP_W +: DAC_W];
      if (!(SKIP && sh_vld[which][k] && sh_code[which][k] == code)) begin
        sh_vld[which][k]  = 1'b1;
        sh_code[which][k] = code;
        if (which == 1) begin
          qa1.push_back(k);
          qd1.push_back(int'(code));
        end else begin
          qa0.push_back(k);
          qd0.push_back(int'(code));
        end
      end
    end
  endtask

  task automatic clear_model();
    qa0.delete(); qd0.delete(); qa1.delete(); qd1.delete();
    for (int w = 0; w < 2; w++)
      for (int k = 0; k < NCH; k++) sh_vld[w][k] = 1'b0;
  endtask

  function automatic logic [NCH*FP_W-1:0] rand_vec();
    logic [NCH*FP_W-1:0] v;
    for (int k = 0; k < NCH*2; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // DAC side of the latency-1 instance: ack driver, hold checks, write checks.
  bit                ack_r = 1'b0;
  bit                in_wr = 1'b0;
  bit                stray_en = 1'b0;
  bit                fix_d2 = 1'b0;
  bit                hold4 = 1'b0;
  int                max_delay = 0;
  int                cur_d = 0;
  int                wcnt = 0;
  int                delay_sum = 0;
  int                wr1_cnt = 0;
  int                wr0_cnt = 0;
  logic [DAC_W-1:0]  held_data;
  logic [CHW-1:0]    held_addr;
  logic [FP_W-1:0]   held_conv;

  assign bus1.dac_ack = ack_r;

  always @(negedge clk) begin
    if (rst) begin
      ack_r = 1'b0;
      in_wr = 1'b0;
    end else if (bus1.dac_wr) begin
      if (!in_wr) begin
        in_wr     = 1'b1;
        wcnt      = 0;
        cur_d     = fix_d2 ? ((bus1.dac_addr == CHW'(2)) ? 3 : 0)
                           : int'($urandom_range(0, max_delay));
        delay_sum += cur_d;
        held_data = bus1.dac_data;
        held_addr = bus1.dac_addr;
        held_conv = bus1.conv_in;
      end else begin
        chk("hold_data", bus1.dac_data, held_data);
        chk("hold_addr", bus1.dac_addr, held_addr);
        chk("hold_conv_in", bus1.conv_in, held_conv);
      end
      ack_r = !(hold4 && bus1.dac_addr == CHW'(4)) && (wcnt >= cur_d);
      wcnt++;
      if (ack_r) begin
        in_wr = 1'b0;
        wr1_cnt++;
        chk("wr1_expected", qa1.size() > 0, 1);
        if (qa1.size() > 0) begin
          chk("wr1_addr", bus1.dac_addr, qa1.pop_front());
          chk("wr1_data", bus1.dac_data, qd1.pop_front());
        end
      end
    end else begin
      in_wr = 1'b0;
      ack_r = stray_en && ($urandom_range(0, 1) == 1);
    end
  end

  always @(negedge clk) begin
    if (!rst && bus0.dac_wr) begin
      wr0_cnt++;
      chk("wr0_expected", qa0.size() > 0, 1);
      if (qa0.size() > 0) begin
        chk("wr0_addr", bus0.dac_addr, qa0.pop_front());
        chk("wr0_data", bus0.dac_data, qd0.pop_front());
      end
    end
  end

  task automatic run_frame(input int which, input logic [NCH*FP_W-1:0] vec, input bit disturb);
    int done_at, done_cnt, busy_gap, busy_after, busy_fin, exp_len, n_plan, wr_base;
    bit b, d;
    done_at = -1; done_cnt = 0; busy_gap = 0; busy_after = 0; busy_fin = 1;
    n_plan  = (which == 1) ? qa1.size() : qa0.size();
    plan(which, vec);
    n_plan  = ((which == 1) ? qa1.size() : qa0.size()) - n_plan;
    @(negedge clk);
    fp_vec    = vec;
    delay_sum = 0;
    wr_base   = (which == 1) ? wr1_cnt : wr0_cnt;
    if (which == 1) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (disturb && i == 5) begin
        start1 = 1'b1;
        fp_vec = rand_vec();
      end
      b = (which == 1) ? busy1 : busy0;
      d = (which == 1) ? done1 : done0;
      if (d) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at  = i;
          busy_fin = int'(b);
          if (disturb) start1 = 1'b1;
        end
      end else if (done_at < 0) begin
        if (!b) busy_gap++;
      end else if (b) begin
        busy_after++;
      end
      if (done_at > 0 && i >= done_at + 4) break;
    end
    exp_len = NCH * (2 + which) + 1 + ((which == 1) ? delay_sum : 0);
    chk("done_cycle", done_at, exp_len);
    chk("done_pulses", done_cnt, 1);
    chk("busy_during_frame", busy_gap, 0);
    chk("busy_at_done", busy_fin, 0);
    chk("busy_after_done", busy_after, 0);
    chk("write_count", ((which == 1) ? wr1_cnt : wr0_cnt) - wr_base, n_plan);
    chk("writes_outstanding", (which == 1) ? qa1.size() : qa0.size(), 0);
  endtask

  initial begin
    logic [NCH*FP_W-1:0] v;
    bit seen;
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; fp_vec = '0;
    clear_model();
    repeat (3) @(negedge clk);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_wr", bus1.dac_wr, 0);
    chk("rst_addr", bus1.dac_addr, 0);
    chk("rst_data", bus1.dac_data, 0);
    chk("rst_conv_in", bus1.conv_in, 0);
    #1 rst = 1'b0;

    for (int k = 0; k < NCH; k++) v[k*FP_W +: FP_W] = 64'h100 + 64'(k);
    run_frame(1, v, 1'b0);

    fix_d2 = 1'b1;
    for (int k = 0; k < NCH; k++) v[k*FP_W +: FP_W] = 64'h200 + 64'(k);
    run_frame(1, v, 1'b0);
    fix_d2 = 1'b0;

    run_frame(0, v, 1'b0);
    run_frame(0, rand_vec(), 1'b0);

    max_delay = 3;
    stray_en  = 1'b1;
    for (int f = 0; f < 12; f++) begin
      case ($urandom_range(0, 2))
        0: v = rand_vec();
        1: v[$urandom_range(0, NCH-1)*FP_W +: FP_W] = {$urandom, $urandom};
        default: ;
      endcase
      run_frame(1, v, $urandom_range(0, 1) == 1);
    end

    // Reset while channel 4 is waiting for its acknowledge.
    max_delay = 0;
    stray_en  = 1'b0;
    hold4     = 1'b1;
    v = rand_vec();
    plan(1, v);
    @(negedge clk);
    fp_vec = v;
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (bus1.dac_wr && bus1.dac_addr == CHW'(4)) seen = 1'b1;
    end
    chk("wr_on_ch4_reached", seen, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_wr", bus1.dac_wr, 0);
    chk("async_rst_busy", busy1, 0);
    chk("async_rst_done", done1, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    hold4 = 1'b0;
    clear_model();
    run_frame(1, rand_vec(), 1'b0);

    // Repeated and single-channel-changed frames.
    v = rand_vec();
    run_frame(1, v, 1'b0);
    run_frame(1, v, 1'b0);
    v[5*FP_W +: FP_W] = ~v[5*FP_W +: FP_W];
    run_frame(1, v, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire

// File: doc/dac_channel_scheduler.md
Name: dac_channel_scheduler

Overview:
Time-multiplexes one shared fixed-point-to-DAC converter (64-bit fixed-point in, 14-bit over-range-checked code out) across NUM_CH actuator channels of the SPGD loop. On a start pulse it snapshots all channel values and presents them to the converter one at a time. It waits out the converter latency, then writes each resulting code to the external DAC interface with a wr/ack handshake. It sits between the SPGD perturbation/update engine and the multi-channel DAC write port.

Parameters:
FP_WIDTH, 64, width of each fixed-point channel value
DAC_WIDTH, 14, width of converter output code and DAC data bus
NUM_CH, 8, number of channels sequenced per frame (>=1)
CONV_LATENCY, 1, converter pipeline depth in clk cycles (0 = combinational)
CH_W, $clog2(NUM_CH) (min 1), channel address width (derived, not overridden)

Ports:
clk  input  1  system clock, all state rising-edge
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle request to run one frame
fp_vec  input  NUM_CH*FP_WIDTH  channel values; channel k at [k*FP_WIDTH +: FP_WIDTH]
conv_in  output  FP_WIDTH  operand to shared converter
conv_out  input  DAC_WIDTH  converter result, valid CONV_LATENCY cycles after conv_in
dac_data  output  DAC_WIDTH  code to DAC
dac_addr  output  CH_W  channel index for dac_data
dac_wr  output  1  write request, held until acknowledged
dac_ack  input  1  DAC accepted write
busy  output  1  frame in progress
done  output  1  one-cycle pulse at frame completion

Behaviour:
- Reset (async, active-high): all outputs 0, FSM IDLE, snapshot bank 0, channel counter 0, latency counter 0. dac_wr drops immediately on rst assertion; an in-flight frame is abandoned, no done pulse.
- States: IDLE, ISSUE, WAIT, WRITE, FIN.
- IDLE: start=1 at edge -> snapshot fp_vec into bank, ch=0, busy=1, go ISSUE. start while not IDLE is ignored, not queued.
- ISSUE (1 cycle): conv_in <= bank[ch]; latency counter loaded with CONV_LATENCY. Next is WAIT, or WRITE directly if CONV_LATENCY=0.
- WAIT: decrement counter each cycle. Go WRITE when it reaches 1, so WAIT lasts exactly CONV_LATENCY cycles.
- WRITE entry: dac_data <= conv_out, dac_addr <= ch, dac_wr <= 1. dac_data/addr/conv_in stay stable while dac_wr=1.
- Handshake: a transfer completes on any edge with dac_wr=1 and dac_ack=1. dac_ack while dac_wr=0 is ignored. After the transfer, dac_wr=0 for at least one cycle.
- After the transfer: if ch==NUM_CH-1 go FIN, else ch++ and go ISSUE.
- FIN (1 cycle): done=1, busy=0, then IDLE. A start during FIN is ignored.
- Per-channel cost with immediate ack: 1 + CONV_LATENCY + 1 cycles. Frame time is NUM_CH times that, plus 1 FIN cycle.
- No arithmetic on data: codes pass through unmodified. Saturation is handled in the converter.
- conv_in holds its last value in IDLE.

Optional Feature:
SKIP_UNCHANGED_EN:
- Defined: a shadow register plus valid bit per channel holds the last code written; valid bits clear on rst. At WRITE entry, if valid[ch] and conv_out==shadow[ch], no dac_wr is raised and the FSM advances next cycle. Otherwise write normally, then update shadow and set valid. done still pulses.
- Undefined: every channel is written every frame; no shadow logic.

Decomposition:
- Package spgd_dac_pkg: FSM state enum, and a function computing CH_W from NUM_CH.
- One natural sub-module, dac_shadow_bank: shadow/valid storage and compare, instantiated only under SKIP_UNCHANGED_EN.

Test Plan:
- Bench stub converter: conv_out = fp_in[13:0] delayed CONV_LATENCY.
- NUM_CH=8, CONV_LATENCY=1, ack tied 1; fp_vec ch k = 0x100+k; start -> 8 writes, addr 0..7, data 0x100..0x107. done exactly 25 cycles after start edge; busy high throughout.
- ack delayed 3 cycles on ch 2 -> dac_wr held 4 cycles with data 0x102 stable; frame lengthens by 3.
- CONV_LATENCY=0 -> per-channel cost 2 cycles; data still matches the same-cycle conv_out.
- start pulsed again mid-frame, and fp_vec changed after start -> ignored; written data reflects the original snapshot; exactly one done.
- rst asserted while dac_wr=1 on ch 4 -> dac_wr, busy, done 0 immediately. Next start writes from ch 0.
- SKIP_UNCHANGED_EN: two identical frames -> frame 2 has 0 dac_wr pulses and done asserted. Change ch 5 only -> third frame writes only addr 5.
